rx_uart_module: RTL

RX_UART_MODULE -- requirements
Module: rx_uart_module

---
 rtl/rx_uart_pkg.sv | 16 +
 rtl/rx_uart_if.sv | 19 +
 rtl/rx_bps_module.sv | 34 +++
 rtl/rx_uart_module.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rx_uart_pkg.sv
// Shared types and default bit timing for the UART receiver.
package rx_uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 100;
  localparam int unsigned HALF_BIT_DEF     = 50;
  localparam int          CNT_W            = 12;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_uart_if.sv
// Serial-line / byte-output bundle between the receiver and its user.
interface rx_uart_if;
  logic       RX_En_Sig;
  logic       RX_Pin_In;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig;
  logic       Frame_Err;
  logic       Busy;

  modport master (
    output RX_En_Sig, RX_Pin_In,
    input  RX_Data, RX_Done_Sig, Frame_Err, Busy
  );

  modport slave (
    input  RX_En_Sig, RX_Pin_In,
    output RX_Data, RX_Done_Sig, Frame_Err, Busy
  );
endinterface

// File: rtl/rx_bps_module.sv
// Bit-timing counter: strobes BPS_CLK at the half-bit point while Start_Sig
// is high, otherwise once per bit period; held at 0 whenever Count_Sig is low.
module rx_bps_module
  import rx_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned HALF_BIT     = HALF_BIT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic Count_Sig,
  input  logic Start_Sig,
  output logic BPS_CLK
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_half_hit;
  logic             w_full_hit;

  assign w_half_hit = Start_Sig  && (r_cnt == CNT_W'(HALF_BIT - 1));
  assign w_full_hit = !Start_Sig && (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign BPS_CLK    = Count_Sig && (w_half_hit || w_full_hit);

  // Counter restarts on every strobe so each sample point is exactly one period apart.
  always_ff @(posedge CLK) begin
    if (RST)
      r_cnt <= '0;
    else if (!Count_Sig || BPS_CLK)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/rx_uart_module.sv
// 8N1 UART receiver: synchronizes the line, detects the start edge, samples
// mid-bit, and reports either a received byte or a framing error.
module rx_uart_module
  import rx_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned HALF_BIT     = HALF_BIT_DEF
) (
  input  logic     CLK,
  input  logic     RST,
  rx_uart_if.slave bus
);

  logic       r_sync1, r_sync2, r_hist;
  rx_state_e  r_state;
  logic [2:0] r_idx;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_done, r_err, r_busy;

  logic       w_fall, w_count, w_start, w_bps;

  assign w_fall  = r_hist && !r_sync2;
  assign w_start = (r_state == START);
  // Counting stops the same edge enable drops, so the counter is already 0 on abort.
  assign w_count = (r_state inside {START, DATA, STOP}) && bus.RX_En_Sig;

  rx_bps_module #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .HALF_BIT     (HALF_BIT)
  ) u_bps (
    .CLK       (CLK),
    .RST       (RST),
    .Count_Sig (w_count),
    .Start_Sig (w_start),
    .BPS_CLK   (w_bps)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
      r_state <= IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync1 <= bus.RX_Pin_In;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_done  <= 1'b0;
      r_err   <= 1'b0;

      if (r_state != IDLE && !bus.RX_En_Sig) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_fall && bus.RX_En_Sig) begin
              r_state <= START;
              r_busy  <= 1'b1;
            end
          end
          START: begin
            if (w_bps) begin
              if (!r_sync2) begin
                r_state <= DATA;
                r_idx   <= '0;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          DATA: begin
            if (w_bps) begin
              r_shift[r_idx] <= r_sync2;
              if (r_idx == 3'd7)
                r_state <= STOP;
              else
                r_idx <= r_idx + 3'd1;
            end
          end
          STOP: begin
            if (w_bps) begin
              if (r_sync2) begin
                r_data  <= r_shift;
                r_done  <= 1'b1;
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_err   <= 1'b1;
                r_state <= WAIT_HIGH;
              end
            end
          end
          WAIT_HIGH: begin
            // A held-low break must release before another start edge can count.
            if (r_sync2) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.RX_Data     = r_data;
  assign bus.RX_Done_Sig = r_done;
  assign bus.Frame_Err   = r_err;
  assign bus.Busy        = r_busy;

endmodule
